// File: rtl/condlogic_it.sv
// condlogic_it: NZCV flag register, condition evaluation and write gating; IT predication FSM built only when CONDLOGIC_IT_EN is defined
module condlogic_it #(
  parameter int MAXIT = 4,
  localparam int LW = $clog2(MAXIT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             NoWrite,
  input  logic             PCS,
  input  logic             NextPC,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             ITStart,
  input  logic [3:0]       ITCond,
  input  logic [MAXIT-2:0] ITMask,
  input  logic [LW-1:0]    ITLen,
  input  logic             InstrDone,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic             CondEx,
  output logic             ITActive,
  output logic             ITErr
);
  logic [3:0] eff_cond;
  logic [1:0] flag_write;
  logic       cond_exq;
  function automatic logic condcheck(input logic [3:0] c, input logic [3:0] f);
    logic b;
    b = c[3:1] == 3'd0 ? f[2] :
        c[3:1] == 3'd1 ? f[1] :
        c[3:1] == 3'd2 ? f[3] :
        c[3:1] == 3'd3 ? f[0] :
        c[3:1] == 3'd4 ? f[1] & ~f[2] :
        c[3:1] == 3'd5 ? f[3] ~^ f[0] :
        c[3:1] == 3'd6 ? ~f[2] & (f[3] ~^ f[0]) : 1'b1;
    return c[3:1] == 3'd7 ? 1'b1 : b ^ c[0];
  endfunction
`ifdef CONDLOGIC_IT_EN
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t           state, state_n;
  logic [3:0]       cur_cond, cur_cond_n;
  logic [LW-1:0]    rem, rem_n;
  logic [MAXIT-2:0] mask, mask_n;
  logic             err;
  logic             start_ok;
  assign start_ok = ITStart && ITLen != '0 && ITLen <= LW'(MAXIT);
  // Block context registers; a rejected or nested start only sets the sticky error
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      cur_cond <= 4'b1110;
      rem      <= '0;
      mask     <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      cur_cond <= cur_cond_n;
      rem      <= rem_n;
      mask     <= mask_n;
      err      <= err | (ITStart & ~(state == IDLE & start_ok));
    end
  // Load a block on a legal start, step the condition on each completed instruction
  always_comb begin
    state_n    = state;
    cur_cond_n = cur_cond;
    rem_n      = rem;
    mask_n     = mask;
    if (state == IDLE && start_ok) begin
      state_n    = ACTIVE;
      cur_cond_n = ITCond;
      rem_n      = ITLen;
      mask_n     = ITMask;
    end else if (state == ACTIVE && InstrDone) begin
      if (rem > LW'(1)) begin
        rem_n      = rem - LW'(1);
        cur_cond_n = {ITCond[3:1], ITCond[0] ^ ~mask[0]};
        mask_n     = mask >> 1;
      end else
        state_n = IDLE;
    end
  end
  assign ITActive = state == ACTIVE;
  assign ITErr    = err;
  assign eff_cond = ITActive ? cur_cond : Cond;
`else
  logic unused_it;
  assign unused_it = ^{ITStart, ITCond, ITMask, ITLen, InstrDone};
  assign ITActive  = 1'b0;
  assign ITErr     = 1'b0;
  assign eff_cond  = Cond;
`endif
  assign CondEx     = condcheck(eff_cond, Flags);
  assign flag_write = FlagW & {2{CondEx}};
  // Flag groups update independently; the condition result is delayed one cycle for write gating
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      Flags    <= '0;
      cond_exq <= 1'b0;
    end else begin
      if (flag_write[1]) Flags[3:2] <= ALUFlags[3:2];
      if (flag_write[0]) Flags[1:0] <= ALUFlags[1:0];
      cond_exq <= CondEx;
    end
  assign RegWrite = RegW & cond_exq;
  assign MemWrite = MemW & cond_exq & ~NoWrite;
  assign PCWrite  = (PCS & cond_exq) | NextPC;
endmodule

// File: tb/tb_condlogic_it.sv
// tb_condlogic_it: vector table, directed IT sequences and randomized model comparison for condlogic_it
module tb_condlogic_it;
  localparam int MAXIT = 4;
  localparam int LW = $clog2(MAXIT + 1);
`ifdef CONDLOGIC_IT_EN
  localparam bit IT_EN = 1'b1;
`else
  localparam bit IT_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] Cond, ALUFlags, ITCond, Flags;
  logic [1:0] FlagW;
  logic NoWrite, PCS, NextPC, RegW, MemW, ITStart, InstrDone;
  logic [MAXIT-2:0] ITMask;
  logic [LW-1:0] ITLen;
  logic PCWrite, RegWrite, MemWrite, CondEx, ITActive, ITErr;
  int n_checks = 0, n_fail = 0;
  typedef struct packed {logic [3:0] cond; logic [3:0] nzcv; logic exp;} vec_t;
  vec_t vecs [18];
  logic [3:0] mflags, eff;
  logic mcq, merr, cex, act;
  logic [3:0] itq [$];
  always #5 clk = ~clk;
  condlogic_it #(.MAXIT(MAXIT)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .NoWrite(NoWrite), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .ITStart(ITStart), .ITCond(ITCond), .ITMask(ITMask), .ITLen(ITLen),
    .InstrDone(InstrDone), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .Flags(Flags), .CondEx(CondEx), .ITActive(ITActive),
    .ITErr(ITErr)
  );
  task automatic check(input string name, input logic [3:0] actual, input logic [3:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'ha: return n == v;
      4'hb: return n != v;
      4'hc: return !z && n == v;
      4'hd: return z || n != v;
      default: return 1'b1;
    endcase
  endfunction
  task automatic clear_inputs;
    Cond = 4'he; ALUFlags = '0; FlagW = '0; NoWrite = 0; PCS = 0; NextPC = 0;
    RegW = 0; MemW = 0; ITStart = 0; ITCond = '0; ITMask = '0; ITLen = '0; InstrDone = 0;
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset;
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask
  task automatic load_flags(input logic [3:0] f);
    Cond = 4'he; FlagW = 2'b11; ALUFlags = f;
    tick();
    FlagW = 2'b00; ALUFlags = 4'h0;
  endtask
  task automatic done_after(input int gap);
    repeat (gap) tick();
    InstrDone = 1;
    tick();
    InstrDone = 0;
    #1;
  endtask
  initial begin
    vecs = '{
      '{4'h0, 4'b0100, 1'b1}, '{4'h1, 4'b0100, 1'b0}, '{4'h2, 4'b0010, 1'b1},
      '{4'h3, 4'b0010, 1'b0}, '{4'h4, 4'b1000, 1'b1}, '{4'h5, 4'b1000, 1'b0},
      '{4'h6, 4'b0000, 1'b0}, '{4'h7, 4'b0000, 1'b1}, '{4'h8, 4'b0010, 1'b1},
      '{4'h9, 4'b0110, 1'b1}, '{4'ha, 4'b1001, 1'b1}, '{4'hb, 4'b1000, 1'b1},
      '{4'hc, 4'b0000, 1'b1}, '{4'hd, 4'b0100, 1'b1}, '{4'he, 4'b0000, 1'b1},
      '{4'hf, 4'b1111, 1'b1}, '{4'hc, 4'b1000, 1'b0}, '{4'h8, 4'b0110, 1'b0}
    };
    clear_inputs();
    #1;
    check("rst_flags", Flags, 4'h0);
    check("rst_regwrite", RegWrite, 1'b0);
    check("rst_memwrite", MemWrite, 1'b0);
    check("rst_itactive", ITActive, 1'b0);
    check("rst_iterr", ITErr, 1'b0);
    check("rst_pcwrite0", PCWrite, 1'b0);
    NextPC = 1; #1;
    check("rst_pcwrite1", PCWrite, 1'b1);
    Cond = 4'h1; #1;
    check("rst_condex_ne", CondEx, 1'b1);
    Cond = 4'h0; #1;
    check("rst_condex_eq", CondEx, 1'b0);
    NextPC = 0;
    tick();
    do_reset();
    Cond = 4'h0; RegW = 1; MemW = 1; PCS = 1; #1;
    check("eq_condex", CondEx, 1'b0);
    tick();
    check("eq_regwrite", RegWrite, 1'b0);
    check("eq_memwrite", MemWrite, 1'b0);
    check("eq_pcwrite", PCWrite, 1'b0);
    NextPC = 1; #1;
    check("nextpc_pcwrite", PCWrite, 1'b1);
    Cond = 4'he;
    tick();
    NextPC = 0; #1;
    check("al_regwrite", RegWrite, 1'b1);
    check("al_memwrite", MemWrite, 1'b1);
    check("al_pcwrite", PCWrite, 1'b1);
    NoWrite = 1; #1;
    check("nowrite_memwrite", MemWrite, 1'b0);
    clear_inputs();
    do_reset();
    foreach (vecs[i]) begin
      load_flags(vecs[i].nzcv);
      check("vec_flags", Flags, vecs[i].nzcv);
      Cond = vecs[i].cond; RegW = 1; #1;
      check("vec_condex", CondEx, vecs[i].exp);
      tick();
      check("vec_regwrite", RegWrite, vecs[i].exp);
      RegW = 0;
    end
    load_flags(4'b0000);
    Cond = 4'h0; FlagW = 2'b11; ALUFlags = 4'b1111;
    tick();
    FlagW = 2'b00;
    check("flagw_gated", Flags, 4'b0000);
    Cond = 4'he; FlagW = 2'b01; ALUFlags = 4'b1111;
    tick();
    FlagW = 2'b00;
    check("flagw_cv_only", Flags, 4'b0011);
`ifdef CONDLOGIC_IT_EN
    do_reset();
    load_flags(4'b0100);
    ITStart = 1; ITCond = 4'h0; ITLen = LW'(3); ITMask = 3'b001;
    tick();
    ITStart = 0; #1;
    check("it_active1", ITActive, 1'b1);
    check("it_condex1", CondEx, 1'b1);
    done_after(2);
    check("it_condex2", CondEx, 1'b1);
    check("it_active2", ITActive, 1'b1);
    done_after(2);
    check("it_condex3", CondEx, 1'b0);
    check("it_active3", ITActive, 1'b1);
    done_after(2);
    check("it_end_active", ITActive, 1'b0);
    check("it_end_condex", CondEx, 1'b1);
    check("it_end_err", ITErr, 1'b0);
    ITStart = 1; ITCond = 4'h1; ITLen = LW'(2); ITMask = 3'b000;
    tick();
    check("b2b_active", ITActive, 1'b1);
    check("b2b_condex", CondEx, 1'b0);
    InstrDone = 1; ITCond = 4'h1; ITLen = LW'(4);
    tick();
    ITStart = 0; InstrDone = 0; #1;
    check("nest_err", ITErr, 1'b1);
    check("nest_active", ITActive, 1'b1);
    check("nest_condex", CondEx, 1'b1);
    done_after(0);
    check("nest_end_active", ITActive, 1'b0);
    check("nest_err_sticky", ITErr, 1'b1);
    do_reset();
    check("err_cleared", ITErr, 1'b0);
    ITStart = 1; ITLen = LW'(5);
    tick();
    ITStart = 0;
    check("badlen_err", ITErr, 1'b1);
    check("badlen_active", ITActive, 1'b0);
    tick(); tick();
    check("badlen_sticky", ITErr, 1'b1);
    do_reset();
    ITStart = 1; ITLen = LW'(0);
    tick();
    ITStart = 0;
    check("zerolen_err", ITErr, 1'b1);
    check("zerolen_active", ITActive, 1'b0);
`else
    do_reset();
    load_flags(4'b0100);
    Cond = 4'h0; ITStart = 1; ITCond = 4'h1; ITLen = LW'(3); InstrDone = 1; #1;
    check("noit_condex", CondEx, 1'b1);
    tick();
    check("noit_active", ITActive, 1'b0);
    check("noit_condex_after", CondEx, 1'b1);
    ITLen = LW'(5);
    tick();
    ITStart = 0; InstrDone = 0;
    check("noit_err", ITErr, 1'b0);
    check("noit_active2", ITActive, 1'b0);
`endif
    do_reset();
    load_flags(4'b1111);
    ITStart = 1; ITCond = 4'he; ITLen = LW'(3); ITMask = 3'b111;
    tick();
    ITStart = 0;
    done_after(0);
    check("midrst_pre_active", ITActive, IT_EN);
    check("midrst_pre_flags", Flags, 4'b1111);
    NextPC = 1; RegW = 1;
    reset = 1; #1;
    check("midrst_active", ITActive, 1'b0);
    check("midrst_flags", Flags, 4'b0000);
    check("midrst_regwrite", RegWrite, 1'b0);
    check("midrst_pcwrite", PCWrite, 1'b1);
    tick();
    reset = 0;
    for (int s = 0; s < 4; s++) begin
      do_reset();
      mflags = '0; mcq = 0; merr = 0; itq.delete();
      for (int c = 0; c < 300; c++) begin
        Cond = 4'($urandom); ALUFlags = 4'($urandom); FlagW = 2'($urandom);
        NoWrite = 1'($urandom); PCS = 1'($urandom); NextPC = 1'($urandom);
        RegW = 1'($urandom); MemW = 1'($urandom);
        ITStart = $urandom_range(5) == 0; ITLen = LW'($urandom_range(MAXIT + 1));
        ITMask = 3'($urandom); InstrDone = $urandom_range(2) == 0;
        if (itq.size() == 0) ITCond = 4'($urandom);
        #1;
        eff = itq.size() > 0 ? itq[0] : Cond;
        cex = ref_cond(eff, mflags);
        check("rnd_condex", CondEx, cex);
        check("rnd_flags", Flags, mflags);
        check("rnd_regwrite", RegWrite, RegW & mcq);
        check("rnd_memwrite", MemWrite, MemW & mcq & ~NoWrite);
        check("rnd_pcwrite", PCWrite, (PCS & mcq) | NextPC);
        check("rnd_itactive", ITActive, itq.size() > 0);
        check("rnd_iterr", ITErr, merr);
        @(posedge clk);
        if (FlagW[1] && cex) mflags[3:2] = ALUFlags[3:2];
        if (FlagW[0] && cex) mflags[1:0] = ALUFlags[1:0];
        mcq = cex;
        if (IT_EN) begin
          act = itq.size() > 0;
          if (act && InstrDone) void'(itq.pop_front());
          if (ITStart && (act || ITLen == 0 || int'(ITLen) > MAXIT)) merr = 1;
          else if (ITStart) begin
            itq.push_back(ITCond);
            for (int k = 1; k < int'(ITLen); k++) itq.push_back(ITMask[k-1] ? ITCond : ITCond ^ 4'b0001);
          end
        end
        @(negedge clk);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
